// File: rtl/console_input_arbiter_if.sv
// Console input bus: PS/2 and UART byte strobes in, IOBUS read port and occupancy out.
// CONSOLE_IRQ_EN adds the irq line.
interface console_input_arbiter_if #(
  parameter int unsigned AW = 3
);
  logic [7:0]  ps2_data;
  logic        ps2_valid;
  logic [7:0]  uart_data;
  logic        uart_valid;
  logic        io_rd;
  logic        io_addr;
  logic [31:0] io_rdata;
  logic [AW:0] fifo_count;
`ifdef CONSOLE_IRQ_EN
  logic        irq;

  modport master (
    output ps2_data, ps2_valid, uart_data, uart_valid, io_rd, io_addr,
    input  io_rdata, fifo_count, irq
  );
  modport slave (
    input  ps2_data, ps2_valid, uart_data, uart_valid, io_rd, io_addr,
    output io_rdata, fifo_count, irq
  );
`else
  modport master (
    output ps2_data, ps2_valid, uart_data, uart_valid, io_rd, io_addr,
    input  io_rdata, fifo_count
  );
  modport slave (
    input  ps2_data, ps2_valid, uart_data, uart_valid, io_rd, io_addr,
    output io_rdata, fifo_count
  );
`endif
endinterface

// File: rtl/console_input_arbiter.sv
// Merges PS/2 and UART byte strobes into one source-tagged FIFO read over IOBUS.
// Optional: define CONSOLE_IRQ_EN for a registered irq output.
module console_input_arbiter #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  console_input_arbiter_if.slave bus
);

  typedef enum logic {
    SRC_PS2  = 1'b0,
    SRC_UART = 1'b1
  } src_e;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [7:0]    ps2_hold_q, ps2_hold_d, uart_hold_q, uart_hold_d;
  logic          ps2_full_q, ps2_full_d, uart_full_q, uart_full_d;
  logic          ps2_ovr_q, ps2_ovr_d, uart_ovr_q, uart_ovr_d;
  src_e          rr_q, rr_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [8:0]    mem_q [DEPTH];

  logic       empty, full, pop, status_rd, space;
  logic       gnt_ps2, gnt_uart, push;
  logic [8:0] push_word;
  logic       ps2_load, uart_load;
  logic [31:0] status_word;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign pop       = bus.io_rd & ~bus.io_addr & ~empty;
  assign status_rd = bus.io_rd & bus.io_addr;
  assign space     = ~full | pop;

  // rr_q names the source that wins the next tie; every grant hands it to the other source.
  always_comb begin
    gnt_ps2  = 1'b0;
    gnt_uart = 1'b0;
    rr_d     = rr_q;
    if (space) begin
      if (ps2_full_q && uart_full_q) begin
        if (rr_q == SRC_PS2) gnt_ps2 = 1'b1;
        else                 gnt_uart = 1'b1;
      end else if (ps2_full_q) begin
        gnt_ps2 = 1'b1;
      end else if (uart_full_q) begin
        gnt_uart = 1'b1;
      end
    end
    if (gnt_ps2)  rr_d = SRC_UART;
    if (gnt_uart) rr_d = SRC_PS2;
  end

  assign push      = gnt_ps2 | gnt_uart;
  assign push_word = gnt_uart ? {1'b1, uart_hold_q} : {1'b0, ps2_hold_q};

  // A granted holding register may reload from a strobe in the same cycle.
  always_comb begin
    ps2_load    = bus.ps2_valid & (~ps2_full_q | gnt_ps2);
    uart_load   = bus.uart_valid & (~uart_full_q | gnt_uart);
    ps2_full_d  = ps2_load | (ps2_full_q & ~gnt_ps2);
    uart_full_d = uart_load | (uart_full_q & ~gnt_uart);
    ps2_hold_d  = ps2_load ? bus.ps2_data : ps2_hold_q;
    uart_hold_d = uart_load ? bus.uart_data : uart_hold_q;
    ps2_ovr_d   = (bus.ps2_valid & ps2_full_q & ~gnt_ps2) | (ps2_ovr_q & ~status_rd);
    uart_ovr_d  = (bus.uart_valid & uart_full_q & ~gnt_uart) | (uart_ovr_q & ~status_rd);
  end

  always_comb begin
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    status_word         = '0;
    status_word[AW:0]   = count_q;
    status_word[16]     = empty;
    status_word[17]     = full;
    status_word[24]     = ps2_ovr_q;
    status_word[25]     = uart_ovr_q;
    rdata_d = rdata_q;
    if (bus.io_rd) begin
      if (bus.io_addr)  rdata_d = status_word;
      else if (pop)     rdata_d = {1'b1, 22'b0, mem_q[rptr_q]};
      else              rdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps2_hold_q  <= '0;
      uart_hold_q <= '0;
      ps2_full_q  <= 1'b0;
      uart_full_q <= 1'b0;
      ps2_ovr_q   <= 1'b0;
      uart_ovr_q  <= 1'b0;
      rr_q        <= SRC_PS2;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
    end else begin
      ps2_hold_q  <= ps2_hold_d;
      uart_hold_q <= uart_hold_d;
      ps2_full_q  <= ps2_full_d;
      uart_full_q <= uart_full_d;
      ps2_ovr_q   <= ps2_ovr_d;
      uart_ovr_q  <= uart_ovr_d;
      rr_q        <= rr_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      rdata_q     <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_word;
  end

  assign bus.io_rdata   = rdata_q;
  assign bus.fifo_count = count_q;

`ifdef CONSOLE_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = (count_q != '0) | ps2_ovr_q | uart_ovr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_console_input_arbiter.sv
// Randomized and directed bench for console_input_arbiter against a queue-based reference model.
module tb_console_input_arbiter;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  console_input_arbiter_if #(.AW(AW)) bus ();

  console_input_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: FIFO contents as a queue, holding registers, overruns, last granted source.
  logic [8:0]  m_q[$];
  logic        m_hf [2];
  logic [7:0]  m_hd [2];
  logic        m_ovr [2];
  int          m_last;
  logic [31:0] m_rdata;
  logic        m_irq;

  task automatic model_reset();
    m_q.delete();
    for (int s = 0; s < 2; s++) begin
      m_hf[s]  = 1'b0;
      m_hd[s]  = 8'h00;
      m_ovr[s] = 1'b0;
    end
    m_last  = 1;
    m_rdata = 32'h0;
    m_irq   = 1'b0;
  endtask

  task automatic model_step(input logic pv, input logic [7:0] pd, input logic uv,
                            input logic [7:0] ud, input logic rd, input logic ad);
    int          g;
    logic        pop, space;
    logic [31:0] st;
    logic        v [2];
    logic [7:0]  d [2];
    logic        nov [2];
    v[0] = pv; v[1] = uv; d[0] = pd; d[1] = ud;
    pop   = rd && !ad && (m_q.size() != 0);
    space = (m_q.size() < DEPTH) || pop;
    g = -1;
    if (space) begin
      if (m_hf[0] && m_hf[1]) g = 1 - m_last;
      else if (m_hf[0])       g = 0;
      else if (m_hf[1])       g = 1;
    end
    m_irq = (m_q.size() != 0) || m_ovr[0] || m_ovr[1];
    if (rd && !ad) begin
      m_rdata = pop ? (32'h8000_0000 | 32'(m_q[0])) : 32'h0;
    end else if (rd) begin
      st     = 32'(m_q.size());
      st[16] = (m_q.size() == 0);
      st[17] = (m_q.size() == DEPTH);
      st[24] = m_ovr[0];
      st[25] = m_ovr[1];
      m_rdata = st;
    end
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back({g[0], m_hd[g]});
      m_last = g;
    end
    for (int s = 0; s < 2; s++) begin
      nov[s] = v[s] && m_hf[s] && (g != s);
      if (g == s) begin
        m_hf[s] = v[s];
        if (v[s]) m_hd[s] = d[s];
      end else if (!m_hf[s] && v[s]) begin
        m_hf[s] = 1'b1;
        m_hd[s] = d[s];
      end
      m_ovr[s] = (rd && ad) ? nov[s] : (m_ovr[s] || nov[s]);
    end
  endtask

  task automatic cycle(input logic pv, input logic [7:0] pd, input logic uv,
                       input logic [7:0] ud, input logic rd, input logic ad);
    bus.ps2_valid  = pv;
    bus.ps2_data   = pd;
    bus.uart_valid = uv;
    bus.uart_data  = ud;
    bus.io_rd      = rd;
    bus.io_addr    = ad;
    model_step(pv, pd, uv, ud, rd, ad);
    @(posedge clk);
    #1;
    bus.ps2_valid  = 1'b0;
    bus.uart_valid = 1'b0;
    bus.io_rd      = 1'b0;
    bus.io_addr    = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.io_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h exp 00000000", bus.io_rdata);
    end
    checks++;
    if (bus.fifo_count !== 4'd0) begin
      errors++; $display("FAIL reset_count got %0d exp 0", bus.fifo_count);
    end
  endtask

  task automatic test_single_ps2();
    do_reset();
    cycle(1'b1, 8'h1C, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (bus.fifo_count !== 4'd0) begin
      errors++; $display("FAIL single_latency1 got %0d exp 0", bus.fifo_count);
    end
    idle();
    checks++;
    if (bus.fifo_count !== 4'd1) begin
      errors++; $display("FAIL single_latency2 got %0d exp 1", bus.fifo_count);
    end
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (bus.io_rdata !== 32'h8000_001C) begin
      errors++; $display("FAIL single_data got %h exp 8000001c", bus.io_rdata);
    end
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (bus.io_rdata !== 32'h0001_0000) begin
      errors++; $display("FAIL single_status got %h exp 00010000", bus.io_rdata);
    end
  endtask

  task automatic test_tie();
    logic [31:0] exp;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      cycle(1'b1, 8'h1C, 1'b1, 8'h41, 1'b0, 1'b0);
      idle();
      idle();
    end
    checks++;
    if (bus.fifo_count !== 4'd6) begin
      errors++; $display("FAIL tie_count got %0d exp 6", bus.fifo_count);
    end
    for (int i = 0; i < 6; i++) begin
      exp = (i % 2 == 0) ? 32'h8000_001C : 32'h8000_0141;
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (bus.io_rdata !== exp) begin
        errors++; $display("FAIL tie_order idx %0d got %h exp %h", i, bus.io_rdata, exp);
      end
    end
  endtask

  task automatic fill_ps2(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) cycle(1'b1, base + 8'(i), 1'b0, 8'h00, 1'b0, 1'b0);
    idle();
  endtask

  task automatic test_overrun_status();
    do_reset();
    fill_ps2(8, 8'hA0);
    cycle(1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 8'h66, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (bus.io_rdata !== 32'h0202_0008) begin
      errors++; $display("FAIL ovr_status got %h exp 02020008", bus.io_rdata);
    end
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (bus.io_rdata !== 32'h0002_0008) begin
      errors++; $display("FAIL ovr_cleared got %h exp 00020008", bus.io_rdata);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp;
    do_reset();
    fill_ps2(8, 8'hA0);
    cycle(1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (bus.fifo_count !== 4'd8) begin
      errors++; $display("FAIL full_pushpop_count got %0d exp 8", bus.fifo_count);
    end
    checks++;
    if (bus.io_rdata !== 32'h8000_00A0) begin
      errors++; $display("FAIL full_pushpop_data got %h exp 800000a0", bus.io_rdata);
    end
    for (int i = 1; i < 9; i++) begin
      exp = (i < 8) ? (32'h8000_00A0 + 32'(i)) : 32'h8000_0155;
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (bus.io_rdata !== exp || bus.fifo_count !== 4'(8 - i)) begin
        errors++;
        $display("FAIL wrap_order idx %0d got %h/%0d exp %h/%0d",
                 i, bus.io_rdata, bus.fifo_count, exp, 8 - i);
      end
    end
  endtask

  task automatic test_empty_and_reset();
    do_reset();
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (bus.io_rdata !== 32'h0 || bus.fifo_count !== 4'd0) begin
      errors++; $display("FAIL empty_read got %h/%0d exp 00000000/0", bus.io_rdata, bus.fifo_count);
    end
    fill_ps2(5, 8'h30);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (bus.io_rdata !== 32'h0000_0005) begin
      errors++; $display("FAIL five_status got %h exp 00000005", bus.io_rdata);
    end
    do_reset();
    checks++;
    if (bus.io_rdata !== 32'h0 || bus.fifo_count !== 4'd0) begin
      errors++; $display("FAIL midrun_reset got %h/%0d exp 00000000/0", bus.io_rdata, bus.fifo_count);
    end
  endtask

  task automatic test_random();
    logic pv, uv, rd, ad;
    int   rd_pct;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rd_pct = (c < 1000) ? 10 : ((c < 2000) ? 70 : 35);
      pv = ($urandom_range(0, 99) < 40);
      uv = ($urandom_range(0, 99) < 40);
      rd = ($urandom_range(0, 99) < rd_pct);
      ad = ($urandom_range(0, 99) < 25);
      cycle(pv, 8'($urandom_range(0, 255)), uv, 8'($urandom_range(0, 255)), rd, ad);
      checks++;
      if (bus.io_rdata !== m_rdata) begin
        errors++; $display("FAIL rand_rdata cyc %0d got %h exp %h", c, bus.io_rdata, m_rdata);
      end
      checks++;
      if (bus.fifo_count !== 4'(m_q.size())) begin
        errors++; $display("FAIL rand_count cyc %0d got %0d exp %0d", c, bus.fifo_count, m_q.size());
      end
`ifdef CONSOLE_IRQ_EN
      checks++;
      if (bus.irq !== m_irq) begin
        errors++; $display("FAIL rand_irq cyc %0d got %b exp %b", c, bus.irq, m_irq);
      end
`endif
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.ps2_valid  = 1'b0;
    bus.ps2_data   = 8'h00;
    bus.uart_valid = 1'b0;
    bus.uart_data  = 8'h00;
    bus.io_rd      = 1'b0;
    bus.io_addr    = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single_ps2();
    test_tie();
    test_overrun_status();
    test_full_push_pop();
    test_empty_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/console_input_arbiter.md
Name: console_input_arbiter

Overview:
- Shares the single CPU-visible console input FIFO between the PS/2 keyboard receiver and the UART receiver.
- Each source delivers bytes as one-cycle strobes. A per-source holding register plus round-robin arbitration merges them into one source-tagged FIFO.
- The CPU drains the FIFO through the IOBUS slave read port (data and status words).
- Sits between the PS/2 and UART receivers and the IOBUS decoder in the N3 computer top.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- AW, 3, log2(DEPTH).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active low.
- ps2_data  in  8  PS/2 scancode byte.
- ps2_valid  in  1  one-cycle strobe; ps2_data is valid.
- uart_data  in  8  UART RX byte.
- uart_valid  in  1  one-cycle strobe; uart_data is valid.
- io_rd  in  1  IOBUS read strobe, one cycle per access.
- io_addr  in  1  0 = data word, 1 = status word.
- io_rdata  out  32  registered read data.
- fifo_count  out  AW+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: io_rdata = 0, fifo_count = 0, both holding registers empty, both overrun flags 0, round-robin pointer = PS/2 (PS/2 wins the first tie). Asserting rst_n low mid-operation discards all buffered bytes on that edge.
- Holding registers:
  - Each source has hold_data[7:0] and hold_full.
  - A valid strobe while hold_full = 0 loads the byte and sets hold_full.
  - A valid strobe while hold_full = 1 drops the byte and sets that source's sticky overrun flag. The exception is when the same source is granted in that cycle: the new byte is then loaded and no overrun is set.
- Arbitration (each cycle):
  - space = (fifo_count < DEPTH) or (pop this cycle).
  - If space and exactly one hold_full, grant that source.
  - If space and both hold_full, grant the source other than the last granted, then update the pointer.
  - A grant pushes {src, hold_data} into the FIFO (src: 0 = PS/2, 1 = UART) and clears hold_full at the same edge.
  - Byte latency: strobe to FIFO visibility is 2 cycles when uncontended.
- FIFO:
  - Circular buffer with wrapping read/write pointers; fifo_count tracks occupancy.
  - Push and pop in the same cycle leaves the count unchanged, including when full (DEPTH) and when count is 1.
  - No push when full without a pop.
- Data read (io_rd, io_addr = 0):
  - If not empty: pop the head, and next cycle io_rdata = {1'b1, 22'b0, src, byte}.
  - If empty: no pop, io_rdata = 0.
  - Bit 31 is the valid flag.
- Status read (io_rd, io_addr = 1):
  - Next cycle io_rdata has [AW:0] = fifo_count, [16] = empty, [17] = full, [24] = ps2_ovr, [25] = uart_ovr; all other bits 0.
  - Both overrun flags clear on that edge. A new overrun in the same cycle wins: that flag stays 1.
- io_rdata holds its value when io_rd = 0.
- Bytes from one source leave the FIFO in arrival order. No byte from a single source is reordered or duplicated.

Optional Feature:
- Macro: CONSOLE_IRQ_EN.
- Defined: adds port irq, out, 1. irq is registered and equals (fifo_count != 0) | ps2_ovr | uart_ovr as of the previous edge. Reset value 0. It deasserts the cycle after the last pop or status-read clear.
- Not defined: no irq port and no related logic; the CPU polls the status word.

Test Plan:
- Reset, then single PS/2 strobe 0x1C -> fifo_count = 1 after 2 cycles; data read returns 0x8000001C; status then reads empty = 1, count = 0.
- Same-cycle PS/2 0x1C and UART 0x41, repeated 3 times -> FIFO order PS2, UART, PS2, UART, PS2, UART; UART reads as 0x80000141.
- Fill 8 entries with no reads, then 2 more UART strobes -> second strobe sets uart_ovr; status = 0x02020008; a second status read shows overrun cleared.
- FIFO full with a data read and a pending UART hold in the same cycle -> push and pop together, count stays 8; read order is preserved across pointer wrap.
- Data read when empty -> io_rdata = 0x00000000, count stays 0; rst_n low with 5 entries -> count 0 and io_rdata 0 the next cycle.
- With CONSOLE_IRQ_EN: irq rises 1 cycle after the first push, falls 1 cycle after the final pop; an overrun alone also raises irq until the status read.
